lfsr_sng_et: RTL and testbench



---
 rtl/lfsr_polys_pkg.sv | 58 +++++
 rtl/lfsr_next.sv | 12 +
 rtl/lfsr_sng_lane.sv | 52 +++++
 rtl/lfsr_sng_et.sv | 112 +++++++++++
 tb/tb_lfsr_sng_et.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/lfsr_polys_pkg.sv
// Maximal-length Galois (right-shift) LFSR feedback masks per width,
// plus the stochastic-number-generator FSM state type.
package lfsr_polys_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sng_state_t;

  function automatic int unsigned lfsr_poly_count(input int unsigned width);
    int unsigned n;
    case (width)
      4:       n = 2;
      5:       n = 6;
      6:       n = 6;
      7:       n = 6;
      8:       n = 8;
      default: n = 0;
    endcase
    return n;
  endfunction

  // Out-of-range requests return 0; callers must check lfsr_poly_count.
  function automatic logic [31:0] lfsr_poly(input int unsigned width, input int unsigned idx);
    logic [31:0] p;
    p = '0;
    case (width)
      4: case (idx)
        0: p = 32'h9;  1: p = 32'hC;
        default: p = '0;
      endcase
      5: case (idx)
        0: p = 32'h12; 1: p = 32'h14; 2: p = 32'h17;
        3: p = 32'h1B; 4: p = 32'h1D; 5: p = 32'h1E;
        default: p = '0;
      endcase
      6: case (idx)
        0: p = 32'h21; 1: p = 32'h2D; 2: p = 32'h30;
        3: p = 32'h33; 4: p = 32'h36; 5: p = 32'h39;
        default: p = '0;
      endcase
      7: case (idx)
        0: p = 32'h41; 1: p = 32'h44; 2: p = 32'h47;
        3: p = 32'h48; 4: p = 32'h4E; 5: p = 32'h53;
        default: p = '0;
      endcase
      8: case (idx)
        0: p = 32'hB8; 1: p = 32'h8E; 2: p = 32'h95; 3: p = 32'h96;
        4: p = 32'hA6; 5: p = 32'hAF; 6: p = 32'hB1; 7: p = 32'hB2;
        default: p = '0;
      endcase
      default: p = '0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/lfsr_next.sv
// Galois LFSR next-state: shift right, fold the feedback mask in when the LSB is set.
module lfsr_next #(
  parameter int unsigned          WIDTH = 8,
  parameter logic [WIDTH-1:0]     POLY  = WIDTH'(32'hB8)
) (
  input  logic [WIDTH-1:0] state,
  output logic [WIDTH-1:0] next_state_c
);

  assign next_state_c = (state >> 1) ^ (state[0] ? POLY : '0);

endmodule

// File: rtl/lfsr_sng_lane.sv
// One SNG channel: optional private LFSR, comparator against the captured
// binary value, and a count of emitted ones.
module lfsr_sng_lane #(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] POLY        = WIDTH'(32'hB8),
  parameter logic [WIDTH-1:0] START_STATE = WIDTH'(1),
  parameter bit               OWN_LFSR    = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             run,
  input  logic [WIDTH-1:0] bx,
  input  logic [WIDTH-1:0] shared_state,
  output logic [WIDTH-1:0] state,
  output logic             x_c,
  output logic [WIDTH-1:0] ones
);

  logic [WIDTH-1:0] cmp_state;

  if (OWN_LFSR) begin : g_own
    logic [WIDTH-1:0] lfsr_q;
    logic [WIDTH-1:0] lfsr_d_c;
    logic             unused_shared;

    lfsr_next #(.WIDTH(WIDTH), .POLY(POLY)) u_next (
      .state        (lfsr_q),
      .next_state_c (lfsr_d_c)
    );

    // Reseeded on reset and on every accepted start; frozen outside RUN.
    always_ff @(posedge clk) begin
      if (rst || load) lfsr_q <= START_STATE;
      else if (run)    lfsr_q <= lfsr_d_c;
    end

    assign cmp_state     = lfsr_q;
    assign unused_shared = ^shared_state;
  end else begin : g_shared
    assign cmp_state = shared_state;
  end

  assign state = cmp_state;
  assign x_c   = run & (cmp_state < bx);

  always_ff @(posedge clk) begin
    if (rst || load) ones <= '0;
    else if (run)    ones <= ones + WIDTH'(x_c);
  end

endmodule

// File: rtl/lfsr_sng_et.sv
// LFSR stochastic number generator with start/done handshake, programmable
// length, early stop and per-channel ones counters.
module lfsr_sng_et
  import lfsr_polys_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned NUM_INPUTS  = 4,
  parameter int unsigned CORR        = 0,
  parameter int unsigned START_STATE = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [NUM_INPUTS*WIDTH-1:0] Bxs,
  input  logic [WIDTH-1:0]            len,
  input  logic                        stop,
  output logic [NUM_INPUTS-1:0]       Xs,
  output logic                        xs_valid,
  output logic                        busy,
  output logic                        done,
  output logic [WIDTH-1:0]            cnt,
  output logic [NUM_INPUTS*WIDTH-1:0] ones
);

  localparam logic [WIDTH-1:0] SEED         = WIDTH'(START_STATE);
  localparam int unsigned      POLYS_AVAIL  = lfsr_poly_count(WIDTH);
  localparam int unsigned      POLYS_NEEDED = (CORR != 0) ? 1 : NUM_INPUTS;

  if (SEED == '0) begin : g_err_seed
    $error("lfsr_sng_et: START_STATE must be nonzero");
  end
  if (POLYS_AVAIL < POLYS_NEEDED) begin : g_err_poly
    $error("lfsr_sng_et: not enough polynomials for this WIDTH/NUM_INPUTS");
  end

  sng_state_t                  state_q;
  sng_state_t                  state_d;
  logic                        accept_c;
  logic                        run_c;
  logic [WIDTH-1:0]            len_q;
  logic [NUM_INPUTS*WIDTH-1:0] bx_q;
  logic [NUM_INPUTS*WIDTH-1:0] lane_states;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Length end and stop in the same cycle collapse into one termination.
  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept_c = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (((cnt + WIDTH'(1)) == len_q) || stop) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign run_c    = (state_q == RUN);
  assign xs_valid = run_c;
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q <= '0;
      bx_q  <= '0;
      cnt   <= '0;
    end else if (accept_c) begin
      len_q <= (len == '0) ? '1 : len;
      bx_q  <= Bxs;
      cnt   <= '0;
    end else if (run_c) begin
      cnt   <= cnt + WIDTH'(1);
    end
  end

  // Lane 0 always owns an LFSR; in correlated mode the others compare against it.
  for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_lane
    lfsr_sng_lane #(
      .WIDTH       (WIDTH),
      .POLY        (WIDTH'(lfsr_poly(WIDTH, (CORR != 0) ? 0 : gi))),
      .START_STATE (SEED),
      .OWN_LFSR    ((gi == 0) || (CORR == 0))
    ) u_lane (
      .clk          (clk),
      .rst          (rst),
      .load         (accept_c),
      .run          (run_c),
      .bx           (bx_q[gi*WIDTH +: WIDTH]),
      .shared_state (lane_states[WIDTH-1:0]),
      .state        (lane_states[gi*WIDTH +: WIDTH]),
      .x_c          (Xs[gi]),
      .ones         (ones[gi*WIDTH +: WIDTH])
    );
  end

  if (NUM_INPUTS > 1) begin : g_unused_states
    logic unused_states;
    assign unused_states = ^lane_states[NUM_INPUTS*WIDTH-1:WIDTH];
  end

endmodule

// File: tb/tb_lfsr_sng_et.sv
// Bench for lfsr_sng_et: correlated and uncorrelated instances driven in
// lockstep, checked against LFSR orbit tables and fixed expectation vectors.
module tb_lfsr_sng_et;

  localparam int unsigned W = 8;
  localparam int unsigned N = 4;

  logic         clk = 1'b0;
  logic         rst, start, stop;
  logic [N*W-1:0] bxs;
  logic [W-1:0] len;

  logic [N-1:0]   xs0, xs1;
  logic           v0, v1, b0, b1, d0, d1;
  logic [W-1:0]   c0, c1;
  logic [N*W-1:0] o0, o1;

  always #5 clk = ~clk;

  lfsr_sng_et #(.WIDTH(W), .NUM_INPUTS(N), .CORR(0), .START_STATE(1)) dut0 (
    .clk(clk), .rst(rst), .start(start), .Bxs(bxs), .len(len), .stop(stop),
    .Xs(xs0), .xs_valid(v0), .busy(b0), .done(d0), .cnt(c0), .ones(o0)
  );

  lfsr_sng_et #(.WIDTH(W), .NUM_INPUTS(N), .CORR(1), .START_STATE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .Bxs(bxs), .len(len), .stop(stop),
    .Xs(xs1), .xs_valid(v1), .busy(b1), .done(d1), .cnt(c1), .ones(o1)
  );

  int checks = 0;
  int errors = 0;

  logic [W-1:0] polys [N];
  logic [W-1:0] orb [N][255];

  typedef struct {
    logic [N*W-1:0] bxs;
    logic [W-1:0]   len;
    int             stop_at;
    int             exp_cnt;
    logic [N*W-1:0] exp_ones;
    bit             ones_known;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Stream bit k of channel i: k-th state of that channel's orbit below Bx.
  function automatic logic [N-1:0] exp_xs(input int d, input logic [N*W-1:0] bx, input int k);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++)
      r[i] = orb[(d != 0) ? 0 : i][k] < bx[i*W +: W];
    return r;
  endfunction

  task automatic check_idle_zero(input string tag);
    chk({tag, "_xs"},    64'({xs0, xs1}), 64'(0));
    chk({tag, "_valid"}, 64'({v0, v1}),   64'(0));
    chk({tag, "_busy"},  64'({b0, b1}),   64'(0));
    chk({tag, "_done"},  64'({d0, d1}),   64'(0));
    chk({tag, "_cnt"},   64'({c0, c1}),   64'(0));
    chk({tag, "_ones"},  64'({o0, o1}),   64'(0));
  endtask

  // Called in IDLE just after an edge; returns in IDLE just after an edge.
  task automatic run_stream(input logic [N*W-1:0] bx, input logic [W-1:0] ln, input int stop_at);
    int L, last;
    int om0 [N];
    int om1 [N];
    logic [N-1:0] ex0, ex1;
    logic [N*W-1:0] eo0, eo1;
    L    = (ln == 0) ? 255 : int'(ln);
    last = (stop_at > 0 && stop_at < L) ? stop_at : L;
    for (int i = 0; i < N; i++) begin
      om0[i] = 0;
      om1[i] = 0;
    end
    bxs = bx; len = ln; start = 1'b1; stop = 1'b0;
    tick();
    for (int k = 0; k < last; k++) begin
      ex0 = exp_xs(0, bx, k);
      ex1 = exp_xs(1, bx, k);
      chk("xs_uncorr", 64'(xs0), 64'(ex0));
      chk("xs_corr",   64'(xs1), 64'(ex1));
      chk("run_valid", 64'({v0, v1}), 64'(2'b11));
      chk("run_busy",  64'({b0, b1}), 64'(2'b11));
      chk("run_done",  64'({d0, d1}), 64'(0));
      chk("run_cnt",   64'({c0, c1}), 64'({W'(k), W'(k)}));
      if (bx[W-1:0] <= bx[2*W-1:W])
        chk("corr_order", 64'(xs1[0] & ~xs1[1]), 64'(0));
      for (int i = 0; i < N; i++) begin
        om0[i] += int'(ex0[i]);
        om1[i] += int'(ex1[i]);
      end
      // Starts and operand changes while running must be ignored.
      start = 1'($urandom_range(1, 0));
      bxs   = N*W'($urandom);
      len   = W'($urandom);
      stop  = (k + 1 == stop_at);
      tick();
    end
    for (int i = 0; i < N; i++) begin
      eo0[i*W +: W] = W'(om0[i]);
      eo1[i*W +: W] = W'(om1[i]);
    end
    chk("done_pulse", 64'({d0, d1}), 64'(2'b11));
    chk("done_valid", 64'({v0, v1}), 64'(0));
    chk("done_busy",  64'({b0, b1}), 64'(2'b11));
    chk("done_xs",    64'({xs0, xs1}), 64'(0));
    chk("done_cnt",   64'({c0, c1}), 64'({W'(last), W'(last)}));
    chk("done_ones0", 64'(o0), 64'(eo0));
    chk("done_ones1", 64'(o1), 64'(eo1));
    start = 1'b1;
    stop  = 1'($urandom_range(1, 0));
    bxs   = N*W'($urandom);
    tick();
    chk("idle_done",  64'({d0, d1}), 64'(0));
    chk("idle_busy",  64'({b0, b1}), 64'(0));
    chk("idle_valid", 64'({v0, v1}), 64'(0));
    chk("idle_cnt",   64'({c0, c1}), 64'({W'(last), W'(last)}));
    chk("idle_ones0", 64'(o0), 64'(eo0));
    chk("idle_ones1", 64'(o1), 64'(eo1));
    start = 1'b0;
    stop  = 1'b0;
  endtask

  initial begin
    logic [W-1:0] s;
    logic [N*W-1:0] bx;
    int ln, sa;

    polys = '{8'hB8, 8'h8E, 8'h95, 8'h96};
    for (int c = 0; c < N; c++) begin
      s = 8'd1;
      for (int k = 0; k < 255; k++) begin
        orb[c][k] = s;
        s = (s >> 1) ^ (s[0] ? polys[c] : 8'h00);
      end
    end

    vecs[0] = '{32'h80808080, 8'd0,   0, 255, 32'h7F7F7F7F, 1'b1};
    vecs[1] = '{32'h8001FF00, 8'd0,   0, 255, 32'h7F00FE00, 1'b1};
    vecs[2] = '{32'hFF008040, 8'd0,   0, 255, 32'hFE007F3F, 1'b1};
    vecs[3] = '{32'h80808080, 8'd16,  5,   5, 32'h0,        1'b0};
    vecs[4] = '{32'h01C80200, 8'd1,   0,   1, 32'h00010100, 1'b1};
    vecs[5] = '{32'h5A3CC311, 8'd3,   3,   3, 32'h0,        1'b0};
    vecs[6] = '{32'hFF000100, 8'd255, 0, 255, 32'hFE000000, 1'b1};
    vecs[7] = '{32'hFFFFFFFF, 8'd2,   0,   2, 32'h02020202, 1'b1};

    rst = 1'b1; start = 1'b0; stop = 1'b0; bxs = '0; len = '0;
    tick(); tick();
    check_idle_zero("reset");
    rst = 1'b0;
    tick();
    check_idle_zero("post_reset");

    for (int v = 0; v < 8; v++) begin
      run_stream(vecs[v].bxs, vecs[v].len, vecs[v].stop_at);
      chk("vec_cnt", 64'({c0, c1}), 64'({W'(vecs[v].exp_cnt), W'(vecs[v].exp_cnt)}));
      if (vecs[v].ones_known) begin
        chk("vec_ones0", 64'(o0), 64'(vecs[v].exp_ones));
        chk("vec_ones1", 64'(o1), 64'(vecs[v].exp_ones));
      end
    end

    // Reset on the 7th valid cycle of a length-20 stream.
    bx = 32'h40C02080;
    bxs = bx; len = 8'd20; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 7; k++) begin
      chk("pre_rst_xs0", 64'(xs0), 64'(exp_xs(0, bx, k)));
      chk("pre_rst_xs1", 64'(xs1), 64'(exp_xs(1, bx, k)));
      if (k == 6) rst = 1'b1;
      tick();
    end
    check_idle_zero("rst_mid_run");
    rst = 1'b0;
    tick();
    check_idle_zero("after_rst");
    run_stream(bx, 8'd20, 0);
    chk("replay_cnt", 64'({c0, c1}), 64'({8'd20, 8'd20}));

    for (int r = 0; r < 8; r++) begin
      bx = N*W'($urandom);
      ln = ($urandom_range(9, 0) == 0) ? 0 : int'($urandom_range(40, 1));
      sa = ($urandom_range(1, 0) == 1) ? int'($urandom_range(45, 1)) : 0;
      run_stream(bx, W'(ln), sa);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
